reg_file_responder: RTL and testbench

REG_FILE_RESPONDER -- requirements
Module: reg_file_responder

---
 rtl/reg_file_responder.sv | 159 +++++++++++++++
 tb/tb_reg_file_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_responder.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_responder
// Description : Architectural register file with a handshaked, fixed-latency
//               operand read port (two operands per request) and a single
//               always-ready write-back port with same-edge write bypass.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   read_req_vld/rdy      operand read request handshake
//   read_reg0/1_id        source register indices captured with the request
//   read_fbk_vld/rdy      operand feedback handshake
//   read_reg0/1_val       operand values, stable while read_fbk_vld is high
//   write_vld/rdy         write-back handshake (write_rdy is always 1)
//   write_id              id of the writing instruction
//   write_reg_id/val      write destination and data
//   reg_written_mask      one-hot of write_reg_id while write_vld (combinational)
//   last_write_id         id of the most recent accepted write
//   busy                  read FSM is not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_responder #(
    parameter int NUM_REG     = 8,
    parameter int REG_BIT     = 16,
    parameter int INST_ID_BIT = 8,
    parameter int READ_LAT    = 1,   // legal range 1..7
    parameter int REG_ID_BIT  = $clog2(NUM_REG)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   read_req_vld,
    output logic                   read_req_rdy,
    input  logic [REG_ID_BIT-1:0]  read_reg0_id,
    input  logic [REG_ID_BIT-1:0]  read_reg1_id,
    output logic                   read_fbk_vld,
    input  logic                   read_fbk_rdy,
    output logic [REG_BIT-1:0]     read_reg0_val,
    output logic [REG_BIT-1:0]     read_reg1_val,
    input  logic                   write_vld,
    output logic                   write_rdy,
    input  logic [INST_ID_BIT-1:0] write_id,
    input  logic [REG_ID_BIT-1:0]  write_reg_id,
    input  logic [REG_BIT-1:0]     write_val,
    output logic [NUM_REG-1:0]     reg_written_mask,
    output logic [INST_ID_BIT-1:0] last_write_id,
    output logic                   busy
);

    // Three bits cover the largest legal latency (7).
    localparam int                   C_CNT_BIT  = 3;
    localparam logic [C_CNT_BIT-1:0] C_LAT_LOAD = C_CNT_BIT'(READ_LAT - 1);
    localparam logic [C_CNT_BIT-1:0] C_CNT_ONE  = C_CNT_BIT'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    logic [C_CNT_BIT-1:0]    r_cnt;
    logic [REG_ID_BIT-1:0]   r_rd0_id;
    logic [REG_ID_BIT-1:0]   r_rd1_id;
    logic [REG_BIT-1:0]      r_regs [NUM_REG];

    logic                    w_req_acc;
    logic [REG_BIT-1:0]      w_rd0_val;
    logic [REG_BIT-1:0]      w_rd1_val;

    // ------------------------------------------------------------------------
    // Register storage and write-back
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
            last_write_id <= '0;
        end else if (write_vld) begin
            r_regs[write_reg_id] <= write_val;
            last_write_id        <= write_id;
        end
    end

    always_comb begin
        reg_written_mask = '0;
        if (write_vld) begin
            reg_written_mask[write_reg_id] = 1'b1;
        end
    end

    assign write_rdy = 1'b1;

    // A write landing on the same edge as the sample is forwarded so the
    // consumer never sees a value that is one edge stale.
    assign w_rd0_val = (write_vld && (write_reg_id == r_rd0_id)) ? write_val : r_regs[r_rd0_id];
    assign w_rd1_val = (write_vld && (write_reg_id == r_rd1_id)) ? write_val : r_regs[r_rd1_id];

    // ------------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------------
    // In HOLD a new request is only taken together with the feedback
    // handshake, which gives back-to-back reads without passing through IDLE.
    assign read_req_rdy = (r_state == S_IDLE) || ((r_state == S_HOLD) && read_fbk_rdy);
    assign w_req_acc    = read_req_vld && read_req_rdy;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rd0_id      <= '0;
            r_rd1_id      <= '0;
            read_fbk_vld  <= 1'b0;
            read_reg0_val <= '0;
            read_reg1_val <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_acc) begin
                        r_rd0_id <= read_reg0_id;
                        r_rd1_id <= read_reg1_id;
                        r_cnt    <= C_LAT_LOAD;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end else begin
                        read_reg0_val <= w_rd0_val;
                        read_reg1_val <= w_rd1_val;
                        read_fbk_vld  <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (read_fbk_rdy) begin
                        read_fbk_vld <= 1'b0;
                        if (w_req_acc) begin
                            r_rd0_id <= read_reg0_id;
                            r_rd1_id <= read_reg1_id;
                            r_cnt    <= C_LAT_LOAD;
                            r_state  <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_responder
// Description : Self-checking bench for reg_file_responder. Two instances are
//               built, READ_LAT=1 (a) and READ_LAT=3 (b); writes go to both,
//               read requests go to the one picked by sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_vld, fbk_rdy, write_vld;
    logic [2:0]  id0, id1, wreg;
    logic [15:0] wval;
    logic [7:0]  wid;

    logic        a_req_rdy, a_vld, a_wrdy, a_busy;
    logic [15:0] a_v0, a_v1;
    logic [7:0]  a_mask, a_lwid;
    logic        b_req_rdy, b_vld, b_wrdy, b_busy;
    logic [15:0] b_v0, b_v1;
    logic [7:0]  b_mask, b_lwid;

    reg_file_responder #(.READ_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .read_req_vld(req_vld && !sel), .read_req_rdy(a_req_rdy),
        .read_reg0_id(id0), .read_reg1_id(id1),
        .read_fbk_vld(a_vld), .read_fbk_rdy(fbk_rdy),
        .read_reg0_val(a_v0), .read_reg1_val(a_v1),
        .write_vld(write_vld), .write_rdy(a_wrdy), .write_id(wid),
        .write_reg_id(wreg), .write_val(wval),
        .reg_written_mask(a_mask), .last_write_id(a_lwid), .busy(a_busy)
    );

    reg_file_responder #(.READ_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .read_req_vld(req_vld && sel), .read_req_rdy(b_req_rdy),
        .read_reg0_id(id0), .read_reg1_id(id1),
        .read_fbk_vld(b_vld), .read_fbk_rdy(fbk_rdy),
        .read_reg0_val(b_v0), .read_reg1_val(b_v1),
        .write_vld(write_vld), .write_rdy(b_wrdy), .write_id(wid),
        .write_reg_id(wreg), .write_val(wval),
        .reg_written_mask(b_mask), .last_write_id(b_lwid), .busy(b_busy)
    );

    logic        obs_req_rdy, obs_vld, obs_wrdy, obs_busy;
    logic [15:0] obs_v0, obs_v1;
    logic [7:0]  obs_mask, obs_lwid;
    assign obs_req_rdy = sel ? b_req_rdy : a_req_rdy;
    assign obs_vld     = sel ? b_vld     : a_vld;
    assign obs_wrdy    = sel ? b_wrdy    : a_wrdy;
    assign obs_busy    = sel ? b_busy    : a_busy;
    assign obs_v0      = sel ? b_v0      : a_v0;
    assign obs_v1      = sel ? b_v1      : a_v1;
    assign obs_mask    = sel ? b_mask    : a_mask;
    assign obs_lwid    = sel ? b_lwid    : a_lwid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected operand pair and expected vld-rise cycle per read.
    logic [31:0] val_q [$];
    int          rise_q [$];
    logic        prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (obs_vld && !prev_vld) begin
                if (rise_q.size() == 0) fail_now("unexpected_fbk_vld");
                else check("vld_rise_cycle", cyc, rise_q.pop_front());
            end
            if (obs_vld && fbk_rdy) begin
                if (val_q.size() == 0) fail_now("unexpected_fbk_handshake");
                else begin
                    logic [31:0] e;
                    e = val_q.pop_front();
                    check("read_reg0_val", {16'h0, obs_v0}, {16'h0, e[31:16]});
                    check("read_reg1_val", {16'h0, obs_v1}, {16'h0, e[15:0]});
                end
            end
            prev_vld = obs_vld;
        end else begin
            prev_vld = 1'b0;
        end
    end

    // All drivers start and end at #1 after a rising edge.
    task automatic do_write(input logic [2:0] r, input logic [15:0] v, input logic [7:0] id);
        write_vld = 1'b1; wreg = r; wval = v; wid = id;
        @(posedge clk); #1;
        write_vld = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] r0, input logic [2:0] r1,
                           input logic [15:0] e0, input logic [15:0] e1);
        int n;
        n = 0;
        req_vld = 1'b1; id0 = r0; id1 = r1;
        @(negedge clk);
        while (!obs_req_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!obs_req_rdy) fail_now("req_accept_timeout");
        else begin
            val_q.push_back({e0, e1});
            rise_q.push_back(cyc + 1 + (sel ? 3 : 1));
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((obs_busy || val_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (obs_busy || val_q.size() != 0) fail_now("read_complete_timeout");
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [15:0] e0;
        logic [15:0] e1;
    } rd_vec_t;

    rd_vec_t tbl [5];
    rd_vec_t zero_tbl [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd0, 3'd7, 16'h0A05, 16'h7A75};
        tbl[1] = '{3'd1, 3'd2, 16'h1A15, 16'h2A25};
        tbl[2] = '{3'd4, 3'd4, 16'h4A45, 16'h4A45};
        tbl[3] = '{3'd6, 3'd3, 16'h6A65, 16'h3A35};
        tbl[4] = '{3'd5, 3'd0, 16'h5A55, 16'h0A05};
        zero_tbl[0] = '{3'd0, 3'd1, 16'h0, 16'h0};
        zero_tbl[1] = '{3'd2, 3'd3, 16'h0, 16'h0};
        zero_tbl[2] = '{3'd4, 3'd5, 16'h0, 16'h0};
        zero_tbl[3] = '{3'd6, 3'd7, 16'h0, 16'h0};

        sel = 1'b0; req_vld = 1'b0; fbk_rdy = 1'b1; write_vld = 1'b0;
        id0 = '0; id1 = '0; wreg = '0; wval = '0; wid = '0;

        // Reset state, with a write presented to exercise the combinational mask.
        repeat (2) @(posedge clk);
        #1;
        write_vld = 1'b1; wreg = 3'd7; wval = 16'h5555; wid = 8'h33;
        @(negedge clk);
        check("rst_fbk_vld", {31'h0, obs_vld}, 32'h0);
        check("rst_busy", {31'h0, obs_busy}, 32'h0);
        check("rst_req_rdy", {31'h0, obs_req_rdy}, 32'h1);
        check("rst_write_rdy", {31'h0, obs_wrdy}, 32'h1);
        check("rst_mask", {24'h0, obs_mask}, 32'h80);
        check("rst_last_write_id", {24'h0, obs_lwid}, 32'h0);
        check("rst_val0", {16'h0, obs_v0}, 32'h0);
        write_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write r7 and observe mask in the same cycle, id after the edge.
        write_vld = 1'b1; wreg = 3'd7; wval = 16'hAAAA; wid = 8'h5C;
        #1;
        check("wr_mask_r7", {24'h0, obs_mask}, 32'h80);
        @(posedge clk); #1;
        write_vld = 1'b0;
        #1;
        check("last_write_id", {24'h0, obs_lwid}, 32'h5C);
        check("mask_idle", {24'h0, obs_mask}, 32'h0);

        // Basic read at READ_LAT=1.
        do_write(3'd3, 16'h1234, 8'h01);
        do_write(3'd5, 16'h00FF, 8'h02);
        do_read(3'd3, 3'd5, 16'h1234, 16'h00FF);
        wait_idle();

        // Consumer stalls for 4 cycles while r3 is rewritten.
        fbk_rdy = 1'b0;
        do_read(3'd3, 3'd5, 16'h1234, 16'h00FF);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!obs_vld && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!obs_vld) fail_now("stall_vld_timeout");
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            write_vld = 1'b1; wreg = 3'd3; wval = 16'h0001; wid = 8'h10;
            @(negedge clk);
            check("stall_val0", {16'h0, obs_v0}, 32'h1234);
            check("stall_val1", {16'h0, obs_v1}, 32'h00FF);
            check("stall_req_rdy", {31'h0, obs_req_rdy}, 32'h0);
            check("stall_vld", {31'h0, obs_vld}, 32'h1);
        end
        @(posedge clk); #1;
        write_vld = 1'b0;
        fbk_rdy = 1'b1;
        wait_idle();

        // Table-driven reads on both latencies after preloading every register.
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), {4'(i), 4'hA, 4'(i), 4'h5}, 8'(i));
        end
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 5; i++) begin
                do_read(tbl[i].r0, tbl[i].r1, tbl[i].e0, tbl[i].e1);
                wait_idle();
            end
        end

        // READ_LAT=3: r2 written on the sample edge is bypassed to both operands.
        sel = 1'b1;
        do_read(3'd2, 3'd2, 16'hBEEF, 16'hBEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_write(3'd2, 16'hBEEF, 8'h22);
        wait_idle();

        // Back-to-back at READ_LAT=1: second request taken on the fbk edge.
        sel = 1'b0;
        do_read(3'd1, 3'd4, 16'h1A15, 16'h4A45);
        do_read(3'd6, 3'd0, 16'h6A65, 16'h0A05);
        @(negedge clk);
        check("b2b_busy_no_idle", {31'h0, obs_busy}, 32'h1);
        @(posedge clk); #1;
        wait_idle();

        // Reset while a READ_LAT=3 read sits in WAIT.
        sel = 1'b1;
        do_read(3'd1, 3'd1, 16'h1A15, 16'h1A15);
        @(negedge clk);
        check("pre_rst_busy", {31'h0, obs_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_fbk_vld", {31'h0, obs_vld}, 32'h0);
        check("midrst_busy", {31'h0, obs_busy}, 32'h0);
        check("midrst_req_rdy", {31'h0, obs_req_rdy}, 32'h1);
        check("midrst_last_write_id", {24'h0, obs_lwid}, 32'h0);
        val_q.delete();
        rise_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_vld", {31'h0, obs_vld}, 32'h0);
        check("post_rst_busy", {31'h0, obs_busy}, 32'h0);
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_read(zero_tbl[i].r0, zero_tbl[i].r1, zero_tbl[i].e0, zero_tbl[i].e1);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
